// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle MIPS sequencing controller
// Optional addi support is enabled by defining MC_CONTROL_ADDI_EN.
module mc_control #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        zero,
  output logic [3:0]  aluctrl,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_source,
  output logic        pc_write,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        illegal,
  output logic [3:0]  state
);

  localparam logic [3:0] S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3,  S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5;
  localparam logic [3:0] S_RTEXEC = 4'd6,  S_RTWB   = 4'd7,  S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

  localparam logic [3:0] ALU_ADD = 4'b0010, ALU_SUB = 4'b0110, ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR = 4'b0001, ALU_SLT = 4'b0111;

  // Timeout fires on the cycle the held count would reach MEM_TIMEOUT.
  localparam logic [7:0] LP_LIMIT = 8'(MEM_TIMEOUT - 1);

  logic [3:0] r_state, w_next;
  logic [5:0] r_opcode, r_funct;
  logic [7:0] r_cnt;
  logic       r_illegal;
  logic       w_timeout, w_bad, w_funct_ok;
  logic [3:0] w_rt_alu;
  logic       w_unused;

  assign w_unused = ^instr[25:6];
  assign state    = r_state;
  assign illegal  = r_illegal;

  assign w_timeout = ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR))
                     && !mem_ready && (r_cnt == LP_LIMIT);

  always_comb begin
    w_funct_ok = 1'b1;
    w_rt_alu   = ALU_ADD;
    case (r_funct)
      6'b100000, 6'b100001: w_rt_alu = ALU_ADD;
      6'b100010, 6'b100011: w_rt_alu = ALU_SUB;
      6'b100100:            w_rt_alu = ALU_AND;
      6'b100101:            w_rt_alu = ALU_OR;
      6'b101010:            w_rt_alu = ALU_SLT;
      default:              w_funct_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_opcode  <= 6'd0;
      r_funct   <= 6'd0;
      r_cnt     <= 8'd0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= w_bad;
      if ((r_state == S_FETCH) && mem_ready) begin
        r_opcode <= instr[31:26];
        r_funct  <= instr[5:0];
      end
      if ((w_next != r_state) || w_timeout) r_cnt <= 8'd0;
      else if (!mem_ready)                  r_cnt <= r_cnt + 8'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    w_bad  = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (mem_ready)      w_next = S_DECODE;
        else if (w_timeout) w_bad  = 1'b1;
      end
      S_DECODE: begin
        case (r_opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTEXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
`ifdef MC_CONTROL_ADDI_EN
          OP_ADDI:      w_next = S_ADDIEX;
`endif
          default: begin
            w_next = S_FETCH;
            w_bad  = 1'b1;
          end
        endcase
      end
      S_MEMADR: w_next = (r_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD, S_MEMWR: begin
        if (mem_ready)      w_next = (r_state == S_MEMRD) ? S_MEMWB : S_FETCH;
        else if (w_timeout) begin
          w_next = S_FETCH;
          w_bad  = 1'b1;
        end
      end
      S_RTEXEC: begin
        w_next = w_funct_ok ? S_RTWB : S_FETCH;
        w_bad  = !w_funct_ok;
      end
`ifdef MC_CONTROL_ADDI_EN
      S_ADDIEX: w_next = S_ADDIWB;
`endif
      default: w_next = S_FETCH;
    endcase
  end

  always_comb begin
    aluctrl    = ALU_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_source  = 2'b00;
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_RTEXEC: begin
        alu_src_a = 1'b1;
        aluctrl   = w_rt_alu;
      end
      S_RTWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        aluctrl   = ALU_SUB;
        pc_source = 2'b01;
        pc_write  = zero;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
      end
`ifdef MC_CONTROL_ADDI_EN
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: reg_write = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule
